// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
package tug_pkg;

  typedef enum logic [1:0] {PLAY, WIN_L, WIN_R, GAME_OVER} tug_state_t;

  // Upper bound on the bar width that onehot() can build.
  localparam int MAX_LIGHTS = 64;

  function automatic logic [MAX_LIGHTS-1:0] onehot(input int unsigned pos);
    logic [MAX_LIGHTS-1:0] v;
    v = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tug_button_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw button level.
module tug_button_edge (
  input  logic clk,
  input  logic Reset,
  input  logic raw,
  output logic press
);

  logic s1, s2, prev;

  // Loading 1 on reset means a button held through reset release is not a press.
  always_ff @(posedge clk) begin
    if (Reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign press = s2 & ~prev;

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: lit position, round/match state and both scores.
module tug_playfield
  import tug_pkg::*;
#(
  parameter int N_LIGHTS    = 9,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                L,
  input  logic                R,
  output logic [N_LIGHTS-1:0] lights,
  output logic                win_left,
  output logic                win_right,
  output logic [SCORE_W-1:0]  score_left,
  output logic [SCORE_W-1:0]  score_right,
  output logic                game_over
);

  localparam int PW = $clog2(N_LIGHTS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0]      POS_C     = PW'(N_LIGHTS / 2);
  localparam logic [PW-1:0]      POS_MAX   = PW'(N_LIGHTS - 1);
  localparam logic [HW-1:0]      HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [SCORE_W-1:0] SMAX      = {SCORE_W{1'b1}};

  if ((N_LIGHTS % 2) == 0 || N_LIGHTS < 3 || N_LIGHTS >= MAX_LIGHTS) begin : g_bad_lights
    $error("tug_playfield: N_LIGHTS must be odd, >= 3 and < %0d", MAX_LIGHTS);
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("tug_playfield: HOLD_CYCLES must be >= 1");
  end

  tug_state_t           state;
  logic [PW-1:0]        pos;
  logic [HW-1:0]        hold;
  logic                 press_l, press_r;
  logic                 mv_l, mv_r;
  logic [SCORE_W-1:0]   left_next, right_next;
  logic [MAX_LIGHTS-1:0] lights_all;
  logic                 unused_lights_hi;

  tug_button_edge u_edge_l (.clk(clk), .Reset(Reset), .raw(L), .press(press_l));
  tug_button_edge u_edge_r (.clk(clk), .Reset(Reset), .raw(R), .press(press_r));

  // Simultaneous presses cancel each other during play.
  assign mv_l = press_l & ~press_r;
  assign mv_r = press_r & ~press_l;

  assign left_next  = (score_left  == SMAX) ? SMAX : score_left  + SCORE_W'(1);
  assign right_next = (score_right == SMAX) ? SMAX : score_right + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= PLAY;
      pos         <= POS_C;
      hold        <= '0;
      score_left  <= '0;
      score_right <= '0;
      win_left    <= 1'b0;
      win_right   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      unique case (state)
        PLAY: begin
          if (mv_l) begin
            if (pos == POS_MAX) begin
              score_left <= left_next;
              hold       <= HOLD_INIT;
              win_left   <= 1'b1;
              if (left_next == SMAX) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state <= WIN_L;
              end
            end else begin
              pos <= pos + 1'b1;
            end
          end else if (mv_r) begin
            if (pos == '0) begin
              score_right <= right_next;
              hold        <= HOLD_INIT;
              win_right   <= 1'b1;
              if (right_next == SMAX) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state <= WIN_R;
              end
            end else begin
              pos <= pos - 1'b1;
            end
          end
        end
        WIN_L, WIN_R: begin
          // Any press, even a simultaneous pair, restarts once the hold-off expires.
          if (hold != '0) begin
            hold <= hold - 1'b1;
          end else if (press_l | press_r) begin
            state     <= PLAY;
            pos       <= POS_C;
            win_left  <= 1'b0;
            win_right <= 1'b0;
          end
        end
        GAME_OVER: begin
        end
        default: state <= PLAY;
      endcase
    end
  end

  assign lights_all       = onehot(32'(pos));
  assign lights           = (state == PLAY) ? lights_all[N_LIGHTS-1:0] : '0;
  assign unused_lights_hi = ^lights_all[MAX_LIGHTS-1:N_LIGHTS];

endmodule

// File: tb/tb_tug_playfield.sv
// Directed plus randomized bench for tug_playfield against a reference game model.
module tb_tug_playfield;

  localparam int N  = 9;
  localparam int C  = N / 2;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic Reset, L, R;

  logic [N-1:0] lights0, lights1;
  logic         wl0, wr0, go0, wl1, wr1, go1;
  logic [2:0]   sl0, sr0;
  logic [0:0]   sl1, sr1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tug_playfield #(.N_LIGHTS(N), .SCORE_W(3), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .Reset(Reset), .L(L), .R(R), .lights(lights0),
    .win_left(wl0), .win_right(wr0), .score_left(sl0), .score_right(sr0), .game_over(go0)
  );

  tug_playfield #(.N_LIGHTS(N), .SCORE_W(1), .HOLD_CYCLES(HC)) dut1 (
    .clk(clk), .Reset(Reset), .L(L), .R(R), .lights(lights1),
    .win_left(wl1), .win_right(wr1), .score_left(sl1), .score_right(sr1), .game_over(go1)
  );

  // Reference model: mode 0=play, 1=left won, 2=right won, 3=match over.
  int m_mode[2], m_pos[2], m_hold[2], m_sl[2], m_sr[2];
  bit m_wl[2], m_wr[2];
  int smax[2] = '{7, 1};
  bit hl[3], hr[3];
  bit pl, pr;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = 0; m_pos[m] = C; m_hold[m] = 0;
      m_sl[m] = 0; m_sr[m] = 0; m_wl[m] = 0; m_wr[m] = 0;
    end
    hl = '{1, 1, 1};
    hr = '{1, 1, 1};
  endtask

  task automatic model_step(input int m, input bit l, input bit r);
    case (m_mode[m])
      0: begin
        if (l && !r) begin
          if (m_pos[m] == N - 1) begin
            m_sl[m] = (m_sl[m] + 1 > smax[m]) ? smax[m] : m_sl[m] + 1;
            m_hold[m] = HC; m_wl[m] = 1;
            m_mode[m] = (m_sl[m] == smax[m]) ? 3 : 1;
          end else m_pos[m]++;
        end else if (r && !l) begin
          if (m_pos[m] == 0) begin
            m_sr[m] = (m_sr[m] + 1 > smax[m]) ? smax[m] : m_sr[m] + 1;
            m_hold[m] = HC; m_wr[m] = 1;
            m_mode[m] = (m_sr[m] == smax[m]) ? 3 : 2;
          end else m_pos[m]--;
        end
      end
      1, 2: begin
        if (m_hold[m] > 0) m_hold[m]--;
        else if (l || r) begin
          m_mode[m] = 0; m_pos[m] = C; m_wl[m] = 0; m_wr[m] = 0;
        end
      end
      default: ;
    endcase
  endtask

  // A press reaches the game two edges after the first sampled high level.
  always @(posedge clk) begin
    if (Reset) model_reset();
    else begin
      pl = hl[1] && !hl[2];
      pr = hr[1] && !hr[2];
      hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = L;
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = R;
      for (int m = 0; m < 2; m++) model_step(m, pl, pr);
    end
  end

  function automatic logic [31:0] exp_lights(input int m);
    return (m_mode[m] == 0) ? (32'd1 << m_pos[m]) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("lights",        32'(lights0), exp_lights(0));
    check("win_left",      32'(wl0),     32'(m_wl[0]));
    check("win_right",     32'(wr0),     32'(m_wr[0]));
    check("score_left",    32'(sl0),     32'(m_sl[0]));
    check("score_right",   32'(sr0),     32'(m_sr[0]));
    check("game_over",     32'(go0),     32'(m_mode[0] == 3));
    check("s1_lights",     32'(lights1), exp_lights(1));
    check("s1_win_left",   32'(wl1),     32'(m_wl[1]));
    check("s1_win_right",  32'(wr1),     32'(m_wr[1]));
    check("s1_score_left", 32'(sl1),     32'(m_sl[1]));
    check("s1_score_right",32'(sr1),     32'(m_sr[1]));
    check("s1_game_over",  32'(go1),     32'(m_mode[1] == 3));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic press_l();
    L = 1'b1; cyc(1); L = 1'b0; cyc(3);
  endtask

  task automatic press_r();
    R = 1'b1; cyc(1); R = 1'b0; cyc(3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lights"},    32'(lights0), 32'h010);
    check({tag, "_scores"},    {sl0, sr0},   32'd0);
    check({tag, "_flags"},     {wl0, wr0, go0}, 32'd0);
    check({tag, "_s1_lights"}, 32'(lights1), 32'h010);
    check({tag, "_s1_flags"},  {sl1, sr1, wl1, wr1, go1}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; L = 1'b0; R = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    Reset = 1'b0;
    cyc(10);
    check_reset_values("idle");

    // One held L press moves exactly once, on the third sampled edge.
    L = 1'b1;
    cyc(2);
    check("held_l_before", 32'(lights0), 32'h010);
    cyc(1);
    check("held_l_move", 32'(lights0), 32'h020);
    cyc(3);
    L = 1'b0;
    cyc(3);
    check("held_l_once", 32'(lights0), 32'h020);
    press_r();
    check("r_back", 32'(lights0), 32'h010);

    L = 1'b1; R = 1'b1;
    cyc(4);
    L = 1'b0; R = 1'b0;
    cyc(3);
    check("both_cancel", 32'(lights0), 32'h010);
    check("both_no_win", {wl0, wr0}, 32'd0);

    // Walk to the left end and win.
    repeat (4) press_l();
    check("left_end", 32'(lights0), 32'h100);
    press_l();
    check("winl_lights", 32'(lights0), 32'h000);
    check("winl_flag", {wl0, go0}, 32'b10);
    check("winl_score", 32'(sl0), 32'd1);
    check("s1_over", {sl1, wl1, go1}, 32'b111);
    press_r();
    R = 1'b0; cyc(1);
    check("hold_ignored", {lights0, wl0}, {9'h000, 1'b1});
    press_r();
    check("new_round", 32'(lights0), 32'h010);
    check("new_round_flag", 32'(wl0), 32'd0);
    check("score_kept", 32'(sl0), 32'd1);

    // Match over on the single-bit score instance stays frozen.
    for (int i = 0; i < 20; i++) begin
      L = 1'($urandom_range(0, 1));
      R = 1'($urandom_range(0, 1));
      cyc(1);
    end
    L = 1'b0; R = 1'b0;
    check("frozen", {lights1, sl1, wl1, go1}, {9'h000, 3'b111});
    Reset = 1'b1; cyc(2); Reset = 1'b0; cyc(1);
    check_reset_values("rst2");

    // Mirror: right win, then reset mid-hold with L held through release.
    cyc(3);
    repeat (5) press_r();
    check("winr_flag", {wr0, sr0, go0}, {1'b1, 3'd1, 1'b0});
    check("s1_winr", {wr1, sr1, go1}, 32'b111);
    L = 1'b1; Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(6);
    check_reset_values("rst_held");
    L = 1'b0;
    cyc(3);
    check("no_spurious", 32'(lights0), 32'h010);

    // Random play, left-biased then right-biased, with rare resets.
    for (int i = 0; i < 600; i++) begin
      L = ($urandom_range(0, 99) < ((i < 300) ? 45 : 25));
      R = ($urandom_range(0, 99) < ((i < 300) ? 25 : 45));
      Reset = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    Reset = 1'b0; L = 1'b0; R = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
- Complete parametrised tug-of-war playfield: one block owns the whole N-light bar, the round and match state, and both players' scores.
- Replaces the per-light neighbour-chained cells.
- Conditions the raw L/R button levels (2-flop sync + rising-edge detect), moves a single lit position, and detects wins at either end.
- Enforces a post-win hold-off, and sits between the button/input stage and the LED/HEX display drivers.

Parameters:
- N_LIGHTS, 9, number of lights; odd, >=3; centre index C = N_LIGHTS/2.
- SCORE_W, 3, width of each score counter; saturates at 2^SCORE_W-1 (match point).
- HOLD_CYCLES, 4, clk cycles presses are ignored after a win; >=1.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- L  in  1  raw left button level, asynchronous.
- R  in  1  raw right button level, asynchronous.
- lights  out  N_LIGHTS  one-hot lit position; bit N_LIGHTS-1 is leftmost; all-zero outside PLAY.
- win_left  out  1  high while in WIN_L or GAME_OVER after a left win.
- win_right  out  1  high while in WIN_R or GAME_OVER after a right win.
- score_left  out  SCORE_W  left rounds won.
- score_right  out  SCORE_W  right rounds won.
- game_over  out  1  a score reached max; match frozen until Reset.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=PLAY, pos=C, lights=1<<C.
  - Scores 0; win_left, win_right, game_over 0; hold counter 0.
  - Sync/prev flops load 1, so a button held through reset release produces no press.
- Conditioning:
  - Each button passes through s1->s2, then prev<=s2.
  - pL = s2L & ~prevL, pR likewise; each is a 1-cycle pulse per rising edge.
  - A button held high counts once.
- Latency: lights/state reflect a press on the 3rd rising clk edge at which the raw input is sampled 1.
- Move: mvL = pL & ~pR, mvR = pR & ~pL. Simultaneous pulses cancel, with no move and no win.
- State PLAY:
  - mvL with pos<N_LIGHTS-1: pos+1. mvR with pos>0: pos-1.
  - mvL with pos==N_LIGHTS-1: score_left+1 (saturating); hold=HOLD_CYCLES; lights=0; win_left=1.
    - Go to GAME_OVER if the new score==max, else WIN_L.
  - mvR with pos==0: mirror of the above into WIN_R/GAME_OVER.
- State WIN_L / WIN_R:
  - hold decrements by 1 per cycle until 0; all presses are ignored while hold!=0.
  - With hold==0, any pulse (pL|pR, including both) starts a new round: PLAY, pos=C, win flags cleared, scores kept.
- State GAME_OVER: lights=0, win flag of the winner held, game_over=1, all presses ignored; exit only via Reset.
- Outputs are registered, or decoded purely from registered state/pos; no combinational path from L/R to any output.
- Score arithmetic is unsigned SCORE_W, never wraps; the increment happens in the same edge as the state change.
- Elaboration assertion: N_LIGHTS odd, >=3; HOLD_CYCLES>=1.

Decomposition:
- Package tug_pkg holds:
  - typedef enum logic [1:0] {PLAY, WIN_L, WIN_R, GAME_OVER} tug_state_t;
  - function onehot(pos) for building the lights vector.
- Sub-module tug_button_edge (clk, Reset, raw, press): sync flops + prev + pulse, instantiated twice.
- Top holds the FSM, the pos register ($clog2(N_LIGHTS) bits), the hold counter and the scores.

Test Plan:
- Reset, then buttons idle 10 cycles -> lights=9'b000010000; scores 0; win flags 0; game_over 0.
- Single L press held 6 cycles -> exactly one move: lights=9'b000100000 after the 3rd sampled edge, unchanged afterwards. Then one R press -> back to 9'b000010000.
- L and R rise in the same cycle -> no movement, no win; lights stay 9'b000010000.
- Five separate L presses from centre -> after the 4th press lights=9'b100000000. After the 5th: lights=0, win_left=1, score_left=1, state WIN_L.
  - Press R 2 cycles after the win -> ignored.
  - Press R after HOLD_CYCLES -> lights=9'b000010000, win_left=0, score_left stays 1.
- SCORE_W=1: first left win -> score_left=1, game_over=1, win_left=1. Further presses for 20 cycles change nothing; Reset -> full reset values.
- Reset asserted mid-hold while L is held through reset release -> reset values; no spurious move once L is sampled after release.
